sfp_norm_row: RTL

Parametrised successor of the per-row special-function (SFP) normaliser in the dual-core datapath. It accepts one row of `COL` signed partial sums and performs one of three operations. In pass-through mode it forwards the row unchanged. In the two normalise modes it divides each lane's magnitude by a shared denominator built from this core's L1 sum and the peer core's L1 sum. The block adds valid/ready handshakes on input and output, a level-based sum exchange with the peer core that can stall, a sign-preserving mode, and a fractional-precision quotient.

---
 rtl/sfp_pkg.sv | 30 +++
 rtl/sfp_serial_div.sv | 71 +++++++
 rtl/sfp_norm_row.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sfp_pkg.sv
`default_nettype none
// =============================================================================
// Module   : sfp_pkg
// Brief    : Shared state/mode encodings and cycle-count helper for sfp_norm_row.
// Revision : 1.0
// =============================================================================
package sfp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SUM  = 3'd1;
    localparam state_t ST_EXCH = 3'd2;
    localparam state_t ST_DIV  = 3'd3;
    localparam state_t ST_OUT  = 3'd4;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_MAG     = 2'b01,
        MODE_SGN     = 2'b10,
        MODE_MAG_ALT = 2'b11
    } mode_e;

    // One quotient bit per cycle over the full integer-plus-fraction width.
    function automatic int div_cycles(input int bw_psum, input int frac);
        return bw_psum + frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_serial_div.sv
`default_nettype none
// =============================================================================
// Module   : sfp_serial_div
// Brief    : Bit-serial restoring divider with saturated quotient output.
// Revision : 1.0
// =============================================================================
module sfp_serial_div
    import sfp_pkg::*;
#(
    parameter int NUM_W = 28,
    parameter int DEN_W = 18,
    parameter int Q_W   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [DEN_W-1:0] den_q, den_d;
    // Quotient shift register with a marker bit: done once the marker reaches the top.
    logic [NUM_W:0]   qsh_q, qsh_d;
    logic [DEN_W:0]   rem_sh;
    logic             fits;
    logic             active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            num_q <= '0;
            den_q <= '0;
            qsh_q <= '0;
        end else begin
            rem_q <= rem_d;
            num_q <= num_d;
            den_q <= den_d;
            qsh_q <= qsh_d;
        end
    end

    always_comb begin
        rem_sh = {rem_q, num_q[NUM_W-1]};
        fits   = (rem_sh >= {1'b0, den_q});
        active = (|qsh_q) && !qsh_q[NUM_W];
        rem_d  = rem_q;
        num_d  = num_q;
        den_d  = den_q;
        qsh_d  = qsh_q;
        if (start) begin
            rem_d = '0;
            num_d = num;
            den_d = den;
            qsh_d = {{NUM_W{1'b0}}, 1'b1};
        end else if (active) begin
            rem_d = fits ? DEN_W'(rem_sh - {1'b0, den_q}) : rem_sh[DEN_W-1:0];
            num_d = {num_q[NUM_W-2:0], 1'b0};
            qsh_d = {qsh_q[NUM_W-1:0], fits};
        end
    end

    assign done = qsh_q[NUM_W];
    assign quot = (|qsh_q[NUM_W-1:Q_W-1]) ? {1'b0, {(Q_W-1){1'b1}}}
                                          : {1'b0, qsh_q[Q_W-2:0]};

endmodule
`default_nettype wire

// File: rtl/sfp_norm_row.sv
`default_nettype none
// =============================================================================
// Module   : sfp_norm_row
// Brief    : Per-row SFP normaliser: pass-through or L1-normalised quotient per lane.
// Revision : 1.0
// =============================================================================
module sfp_norm_row
    import sfp_pkg::*;
#(
    parameter int COL     = 8,
    parameter int BW_PSUM = 20,
    parameter int BW_SUM  = 24,
    parameter int SHIFT   = 7,
    parameter int FRAC    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*BW_PSUM-1:0]   in_data,
    input  logic [1:0]               mode,
    input  logic                     peer_en,
    output logic [BW_SUM-1:0]        sum_local_out,
    output logic                     sum_local_vld,
    input  logic [BW_SUM-1:0]        sum_peer_in,
    input  logic                     sum_peer_vld,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*BW_PSUM-1:0]   out_data,
    output logic                     busy
);

    localparam int DIV_CYC = div_cycles(BW_PSUM, FRAC);
    localparam int DEN_W   = BW_SUM - SHIFT + 1;
    localparam int CNT_W   = $clog2(DIV_CYC);
    localparam int ACC_W   = BW_SUM + BW_PSUM;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV_CYC - 1);
    localparam logic [BW_PSUM-1:0] LANE_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
    localparam logic [BW_PSUM-1:0] LANE_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     norm_q, norm_d;
    logic                     sgn_q, sgn_d;
    logic                     peer_en_q, peer_en_d;
    logic                     rdy_en_q;
    logic [COL-1:0]           neg_q, neg_d;
    logic [COL*BW_PSUM-1:0]   data_q, data_d;
    logic [BW_SUM-1:0]        sum_local_q, sum_local_d;

    logic                     w_accept;
    logic                     w_peer_go;
    logic [BW_SUM-1:0]        w_peer;
    logic [DEN_W-1:0]         w_den;
    logic [ACC_W-1:0]         w_acc;
    logic [BW_SUM-1:0]        w_sum_sat;
    logic [COL*BW_PSUM-1:0]   w_abs;
    logic [COL*BW_PSUM-1:0]   w_res;
    logic [COL-1:0]           w_neg;
    logic [COL-1:0]           div_done;
    logic                     div_start;

    assign w_accept  = in_valid && in_ready;
    assign w_peer_go = sum_peer_vld || !peer_en_q;
    assign w_peer    = peer_en_q ? sum_peer_in : '0;
    // Each term is pre-shifted, so the +1 keeps the denominator nonzero without overflow.
    assign w_den     = DEN_W'((BW_SUM+1)'(sum_local_q >> SHIFT)
                            + (BW_SUM+1)'(w_peer >> SHIFT)
                            + (BW_SUM+1)'(1));

    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic [BW_PSUM-1:0] lane_in;
        logic [BW_PSUM-1:0] quot;

        assign lane_in  = in_data[i*BW_PSUM +: BW_PSUM];
        assign w_neg[i] = lane_in[BW_PSUM-1];
        assign w_abs[i*BW_PSUM +: BW_PSUM] = (lane_in == LANE_MIN) ? LANE_MAX
                                           : (w_neg[i] ? -lane_in : lane_in);

        sfp_serial_div #(
            .NUM_W (DIV_CYC),
            .DEN_W (DEN_W),
            .Q_W   (BW_PSUM)
        ) u_div (
            .clk   (clk),
            .reset (reset),
            .start (div_start),
            .num   ({data_q[i*BW_PSUM +: BW_PSUM], {FRAC{1'b0}}}),
            .den   (w_den),
            .done  (div_done[i]),
            .quot  (quot)
        );

        assign w_res[i*BW_PSUM +: BW_PSUM] = (sgn_q && neg_q[i]) ? -quot : quot;
    end

    always_comb begin : p_sum
        w_acc = '0;
        for (int i = 0; i < COL; i++) begin
            w_acc = w_acc + ACC_W'(data_q[i*BW_PSUM +: BW_PSUM]);
        end
        w_sum_sat = (|w_acc[ACC_W-1:BW_SUM]) ? '1 : w_acc[BW_SUM-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin : p_state
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            norm_q      <= 1'b0;
            sgn_q       <= 1'b0;
            peer_en_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
            neg_q       <= '0;
            data_q      <= '0;
            sum_local_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            norm_q      <= norm_d;
            sgn_q       <= sgn_d;
            peer_en_q   <= peer_en_d;
            rdy_en_q    <= 1'b1;
            neg_q       <= neg_d;
            data_q      <= data_d;
            sum_local_q <= sum_local_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = (mode == MODE_PASS) ? ST_OUT : ST_SUM;
            ST_SUM:  state_d = ST_EXCH;
            ST_EXCH: if (w_peer_go) state_d = ST_DIV;
            ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_data
        cnt_d       = cnt_q;
        norm_d      = norm_q;
        sgn_d       = sgn_q;
        peer_en_d   = peer_en_q;
        neg_d       = neg_q;
        data_d      = data_q;
        sum_local_d = sum_local_q;
        div_start   = 1'b0;
        if (w_accept) begin
            norm_d    = (mode != MODE_PASS);
            sgn_d     = (mode == MODE_SGN);
            peer_en_d = peer_en;
            neg_d     = w_neg;
            data_d    = (mode == MODE_PASS) ? in_data : w_abs;
        end
        case (state_q)
            ST_SUM:  sum_local_d = w_sum_sat;
            ST_EXCH: if (w_peer_go) begin
                div_start = 1'b1;
                cnt_d     = '0;
            end
            ST_DIV:  cnt_d = cnt_q + CNT_W'(1);
            default: ;
        endcase
    end

    always_comb begin : p_out
        in_ready      = (state_q == ST_IDLE) && rdy_en_q;
        out_valid     = (state_q == ST_OUT);
        sum_local_vld = (state_q == ST_EXCH);
        busy          = (state_q != ST_IDLE);
        sum_local_out = sum_local_q;
        out_data      = norm_q ? w_res : data_q;
    end

    a_div_done: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ST_OUT && norm_q) |-> (&div_done));

endmodule
`default_nettype wire
